// File: rtl/full_adder_checker.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_checker
// Purpose  : Latency-aligned response checker for a 1-bit full adder with a
//            saturating error count and {a,b,ci} input-space coverage.
// Options  : FA_CHK_STOP_ON_ERR_EN - the first mismatch ends the run.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_checker #(
   parameter int LAT     = 1,
   parameter int ERR_W   = 8,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vld,
   input  logic             a,
   input  logic             b,
   input  logic             ci,
   input  logic             co,
   input  logic             s,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [7:0]       cov
);

   localparam int                c_to_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_to_w-1:0] c_timeout = c_to_w'(TIMEOUT);
   localparam logic [ERR_W-1:0]  c_err_max = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_leave;
   logic                w_enter;
   logic                w_in_run;
   logic                w_cmp_vld;
   logic [2:0]          w_cmp_idx;
   logic [1:0]          w_cmp_exp;
   logic                w_dl_any;
   logic                w_miss;
   logic                w_cov_full;
   logic                w_timeout;
   logic                w_stop;
   logic [2:0]          w_in_idx;
   logic [1:0]          w_in_exp;
   logic [c_to_w-1:0]   r_to_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic                r_mismatch;
   logic [ERR_W-1:0]    r_err_cnt;
   logic [7:0]          r_cov;

   assign w_in_idx = {a, b, ci};
   assign w_in_exp = {1'b0, a} + {1'b0, b} + {1'b0, ci};
   assign w_in_run = (r_state == S_RUN);

   // Delay line is held empty outside RUN so stale entries never reach a later run.
   generate
      if (LAT == 0) begin : g_lat_zero
         assign w_cmp_vld = w_in_run & vld;
         assign w_cmp_idx = w_in_idx;
         assign w_cmp_exp = w_in_exp;
         assign w_dl_any  = 1'b0;
      end else begin : g_lat_pipe
         logic [LAT-1:0] r_dl_vld;
         logic [2:0]     r_dl_idx [LAT];
         logic [1:0]     r_dl_exp [LAT];

         always_ff @(posedge clk) begin
            if (!rst_n || !w_in_run || w_leave) begin
               r_dl_vld <= '0;
            end else begin
               r_dl_vld[0] <= vld;
               for (int k = 1; k < LAT; k++) begin
                  r_dl_vld[k] <= r_dl_vld[k-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            r_dl_idx[0] <= w_in_idx;
            r_dl_exp[0] <= w_in_exp;
            for (int k = 1; k < LAT; k++) begin
               r_dl_idx[k] <= r_dl_idx[k-1];
               r_dl_exp[k] <= r_dl_exp[k-1];
            end
         end

         assign w_cmp_vld = r_dl_vld[LAT-1];
         assign w_cmp_idx = r_dl_idx[LAT-1];
         assign w_cmp_exp = r_dl_exp[LAT-1];
         assign w_dl_any  = |r_dl_vld;
      end
   endgenerate

   assign w_miss     = w_cmp_vld && (w_cmp_exp != {co, s});
   assign w_cov_full = (r_cov == 8'hFF) && !w_dl_any;
   assign w_timeout  = (r_to_cnt == c_timeout);

`ifdef FA_CHK_STOP_ON_ERR_EN
   assign w_stop = w_miss;
`else
   assign w_stop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_leave = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_RUN;
         S_RUN: begin
            if (w_cov_full || w_timeout || w_stop) begin
               w_next  = S_DONE;
               w_leave = 1'b1;
            end
         end
         S_DONE: if (start) w_next = S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_enter = (w_next == S_RUN) && !w_in_run;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_mismatch <= 1'b0;
         r_err_cnt  <= '0;
         r_cov      <= '0;
         r_to_cnt   <= '0;
      end else begin
         r_busy <= (w_next == S_RUN);
         r_done <= (w_next == S_DONE);
         if (w_enter) begin
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
            r_cov      <= '0;
            r_to_cnt   <= '0;
         end else if (w_in_run) begin
            r_mismatch <= w_miss;
            if (w_cmp_vld) r_cov[w_cmp_idx] <= 1'b1;
            if (w_miss && (r_err_cnt != c_err_max)) r_err_cnt <= r_err_cnt + 1'b1;
            if (!w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
            // Post-edge error count is zero only if none was held and none arrives now.
            if (w_leave) r_pass <= w_cov_full && !w_timeout && (r_err_cnt == '0) && !w_miss;
         end else begin
            r_mismatch <= 1'b0;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign pass     = r_pass;
   assign mismatch = r_mismatch;
   assign err_cnt  = r_err_cnt;
   assign cov      = r_cov;

endmodule
`default_nettype wire
